// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: frame codes, rx_error field masks, arbiter FSM states.
// Latency: n/a (constants and pure helpers only).
// Backpressure: n/a.
package eth_pkg;

  localparam logic [2:0] FRAME_NONE      = 3'b000;
  localparam logic [2:0] FRAME_DATA      = 3'b001;
  localparam logic [2:0] FRAME_ERR_CMD   = 3'b010;
  localparam logic [2:0] FRAME_ERR_DIM   = 3'b011;
  localparam logic [2:0] FRAME_ERR_FRAME = 3'b110;

  // Low nibble carries command-error pulses, high nibble frame-error pulses.
  localparam logic [7:0] RX_ERR_CMD_MASK = 8'h0F;
  localparam logic [7:0] RX_ERR_FRM_MASK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_COMMIT = 2'd2
  } arb_state_t;

  // 8-bit add that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// Bundle between the RX/control path, the TX engine and the frame arbiter.
// Latency: n/a (wiring only).
// Backpressure: TX pulses read only while frame_available is high.
interface eth_tx_frame_arbiter_if;
  import eth_pkg::*;

  logic [7:0] rx_error;
  logic       dim_error;
  logic       data_available;
  logic       read;
  logic [2:0] frame;
  logic       frame_available;
  logic       err_overflow;
  logic [7:0] drop_cnt;

  // Side that sources events and read pulses.
  modport master (
    output rx_error, dim_error, data_available, read,
    input  frame, frame_available, err_overflow, drop_cnt
  );

  // Arbiter side.
  modport slave (
    input  rx_error, dim_error, data_available, read,
    output frame, frame_available, err_overflow, drop_cnt
  );

endinterface

// File: rtl/eth_sat_counter.sv
// Per-type pending-event counter: +1 on inc, -1 on dec, saturates at all-ones.
// Latency: count updates on the edge after inc/dec; sat_hit is combinational.
// Backpressure: none; an inc at saturation is dropped and flagged on sat_hit.
module eth_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             sat_hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic dec_ok;

  // Never decrement through zero; inc and dec together cancel out.
  assign dec_ok  = dec && (count != '0);
  assign sat_hit = inc && !dec_ok && (count == CNT_MAX);

  // Pending count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec_ok && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else if (dec_ok && !inc) begin
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Picks the next TX frame (DATA or one of three error reports) with a starvation guard for DATA.
// Latency: event at cycle N -> frame_available at N+2 from idle; frame updates on the read edge.
// Backpressure: a read is honoured only while frame_available; one dead cycle follows each commit.
module eth_tx_frame_arbiter
  import eth_pkg::*;
#(
  parameter int CNT_W         = 2,
  parameter int MAX_ERR_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  eth_tx_frame_arbiter_if.slave  bus
);

  localparam int              BW        = $clog2(MAX_ERR_BURST + 1);
  localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_ERR_BURST);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] pend_cmd, pend_dim, pend_frm;
  logic             sat_cmd, sat_dim, sat_frm;
  logic [BW-1:0]    burst_cnt;
  logic             data_inflight;
  logic             data_req;
  logic [2:0]       cand;
  logic             commit;
  logic [2:0]       frame_q;
  logic             avail_q;
  logic             ovf_q;
  logic [7:0]       drop_q;
  logic [1:0]       sat_sum;
  logic             ev_cmd, ev_frm;

  assign ev_cmd   = |(bus.rx_error & RX_ERR_CMD_MASK);
  assign ev_frm   = |(bus.rx_error & RX_ERR_FRM_MASK);
  // DATA is offered once per burst of data_available; continuation chunks are not re-offered.
  assign data_req = bus.data_available && !data_inflight;
  assign sat_sum  = {1'b0, sat_cmd} + {1'b0, sat_dim} + {1'b0, sat_frm};

  eth_sat_counter #(.CNT_W(CNT_W)) u_cnt_cmd (
    .clk(clk), .rst(rst), .inc(ev_cmd), .dec(commit && (cand == FRAME_ERR_CMD)),
    .count(pend_cmd), .sat_hit(sat_cmd)
  );
  eth_sat_counter #(.CNT_W(CNT_W)) u_cnt_dim (
    .clk(clk), .rst(rst), .inc(bus.dim_error), .dec(commit && (cand == FRAME_ERR_DIM)),
    .count(pend_dim), .sat_hit(sat_dim)
  );
  eth_sat_counter #(.CNT_W(CNT_W)) u_cnt_frm (
    .clk(clk), .rst(rst), .inc(ev_frm), .dec(commit && (cand == FRAME_ERR_FRAME)),
    .count(pend_frm), .sat_hit(sat_frm)
  );

  // Candidate: starved DATA first, then errors by severity, then DATA.
  always_comb begin
    cand = FRAME_NONE;
    if (data_req && (burst_cnt == BURST_MAX)) cand = FRAME_DATA;
    else if (pend_frm != '0)                  cand = FRAME_ERR_FRAME;
    else if (pend_dim != '0)                  cand = FRAME_ERR_DIM;
    else if (pend_cmd != '0)                  cand = FRAME_ERR_CMD;
    else if (data_req)                        cand = FRAME_DATA;
  end

  // Next-state and commit decode.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cand != FRAME_NONE) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (cand == FRAME_NONE) begin
          state_nxt = S_IDLE;
        end else if (bus.read) begin
          commit    = 1'b1;
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_nxt = (cand != FRAME_NONE) ? S_ARMED : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered frame_available so it rises with S_ARMED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      avail_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      avail_q <= (state_nxt == S_ARMED);
    end
  end

  // Committed frame code, held until the next commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         frame_q <= FRAME_NONE;
    else if (commit) frame_q <= cand;
  end

  // DATA in-flight flag and consecutive-error-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_inflight <= 1'b0;
      burst_cnt     <= '0;
    end else begin
      if (commit && (cand == FRAME_DATA)) data_inflight <= 1'b1;
      else if (!bus.data_available)       data_inflight <= 1'b0;

      if (!data_req)                                     burst_cnt <= '0;
      else if (commit && (cand == FRAME_DATA))           burst_cnt <= '0;
      else if (commit && (burst_cnt != BURST_MAX))       burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Sticky overflow flag and count of events lost to saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      if (sat_sum != 2'd0) ovf_q <= 1'b1;
      drop_q <= sat_add8(drop_q, sat_sum);
    end
  end

  assign bus.frame           = frame_q;
  assign bus.frame_available = avail_q;
  assign bus.err_overflow    = ovf_q;
  assign bus.drop_cnt        = drop_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: directed scenarios then random traffic against a reference model.
// Latency: model advances once per rising edge; outputs compared 1 ns after each edge.
// Backpressure: reads are driven freely, including while no frame is offered.
module tb_eth_tx_frame_arbiter;

  localparam int CNT_W = 2;
  localparam int MAXB  = 4;
  localparam int PMAX  = (1 << CNT_W) - 1;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_DATA = 3'b001;
  localparam logic [2:0] F_CMD  = 3'b010;
  localparam logic [2:0] F_DIM  = 3'b011;
  localparam logic [2:0] F_FRM  = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;

  eth_tx_frame_arbiter_if arb_if ();

  eth_tx_frame_arbiter #(.CNT_W(CNT_W), .MAX_ERR_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (arb_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: pending counts per error type, data bookkeeping, offer phase.
  int         m_pc, m_pd, m_pf, m_burst, m_drop, m_lost;
  bit         m_infl, m_offer, m_cool, m_ovf;
  logic [2:0] m_frame;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_pd = 0; m_pf = 0; m_burst = 0; m_drop = 0;
    m_infl = 0; m_offer = 0; m_cool = 0; m_ovf = 0;
    m_frame = F_NONE;
  endtask

  function automatic logic [2:0] m_cand(input bit req);
    if (req && m_burst == MAXB) return F_DATA;
    if (m_pf > 0) return F_FRM;
    if (m_pd > 0) return F_DIM;
    if (m_pc > 0) return F_CMD;
    if (req)      return F_DATA;
    return F_NONE;
  endfunction

  function automatic int bump(input int p, input bit ev, input bit dc);
    if (ev && !dc) begin
      if (p == PMAX) begin
        m_lost++;
        return p;
      end
      return p + 1;
    end
    if (dc && !ev) return p - 1;
    return p;
  endfunction

  // Apply one clock edge of the spec rules to the model, using the inputs present at the edge.
  task automatic model_step();
    bit         req, com, rd;
    logic [2:0] c;
    req = arb_if.data_available && !m_infl;
    c   = m_cand(req);
    rd  = arb_if.read;
    com = m_offer && rd && (c != F_NONE);
    m_lost = 0;
    m_pc = bump(m_pc, |arb_if.rx_error[3:0], com && c == F_CMD);
    m_pd = bump(m_pd, arb_if.dim_error,      com && c == F_DIM);
    m_pf = bump(m_pf, |arb_if.rx_error[7:4], com && c == F_FRM);
    if (m_lost > 0) m_ovf = 1;
    m_drop = (m_drop + m_lost > 255) ? 255 : m_drop + m_lost;
    if (!req)                     m_burst = 0;
    else if (com && c == F_DATA)  m_burst = 0;
    else if (com && m_burst < MAXB) m_burst++;
    if (com && c == F_DATA)          m_infl = 1;
    else if (!arb_if.data_available) m_infl = 0;
    if (com) m_frame = c;
    if (m_cool) begin
      m_cool  = 0;
      m_offer = (c != F_NONE);
    end else if (m_offer) begin
      if (c == F_NONE) m_offer = 0;
      else if (rd) begin
        m_offer = 0;
        m_cool  = 1;
      end
    end else begin
      m_offer = (c != F_NONE);
    end
  endtask

  task automatic compare_all();
    check("frame",           {29'd0, arb_if.frame},   {29'd0, m_frame});
    check("frame_available", {31'd0, arb_if.frame_available}, {31'd0, m_offer});
    check("err_overflow",    {31'd0, arb_if.err_overflow},    {31'd0, m_ovf});
    check("drop_cnt",        {24'd0, arb_if.drop_cnt},        m_drop);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_avail();
    int n = 0;
    while (!arb_if.frame_available && n < 20) begin
      step();
      n++;
    end
    check("avail_wait", {31'd0, arb_if.frame_available}, 32'd1);
  endtask

  task automatic read_one(input logic [2:0] exp_code, input string tag);
    wait_avail();
    arb_if.read = 1'b1;
    step();
    arb_if.read = 1'b0;
    check(tag, {29'd0, arb_if.frame}, {29'd0, exp_code});
  endtask

  task automatic drive_idle();
    arb_if.rx_error = 8'h00;
    arb_if.dim_error = 1'b0;
    arb_if.data_available = 1'b0;
    arb_if.read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    model_reset();
    #12;
    rst = 1'b0;
    compare_all();
    check("rst_frame", {29'd0, arb_if.frame}, 32'd0);
    check("rst_avail", {31'd0, arb_if.frame_available}, 32'd0);

    // Single dim error, no data: offered two edges later, committed as 011.
    arb_if.dim_error = 1'b1;
    step();
    arb_if.dim_error = 1'b0;
    check("dim_avail_n1", {31'd0, arb_if.frame_available}, 32'd0);
    step();
    check("dim_avail_n2", {31'd0, arb_if.frame_available}, 32'd1);
    arb_if.read = 1'b1;
    step();
    arb_if.read = 1'b0;
    check("dim_frame", {29'd0, arb_if.frame}, {29'd0, F_DIM});
    check("dim_avail_commit", {31'd0, arb_if.frame_available}, 32'd0);
    step();
    check("dim_avail_idle", {31'd0, arb_if.frame_available}, 32'd0);

    // Simultaneous frame and command error: 110 first, read held into the dead cycle, then 010.
    arb_if.rx_error = 8'h11;
    step();
    arb_if.rx_error = 8'h00;
    wait_avail();
    arb_if.read = 1'b1;
    step();
    check("frm_first", {29'd0, arb_if.frame}, {29'd0, F_FRM});
    step();
    arb_if.read = 1'b0;
    check("read_in_commit", {29'd0, arb_if.frame}, {29'd0, F_FRM});
    read_one(F_CMD, "cmd_second");
    step();
    // Read in idle with nothing pending is ignored.
    arb_if.read = 1'b1;
    step();
    step();
    arb_if.read = 1'b0;
    check("read_in_idle", {29'd0, arb_if.frame}, {29'd0, F_CMD});
    check("idle_avail", {31'd0, arb_if.frame_available}, 32'd0);

    // Five command errors, no reads: counter saturates at 3, two events dropped.
    arb_if.rx_error = 8'h01;
    for (int i = 0; i < 5; i++) step();
    arb_if.rx_error = 8'h00;
    step();
    check("sat_ovf", {31'd0, arb_if.err_overflow}, 32'd1);
    check("sat_drop", {24'd0, arb_if.drop_cnt}, 32'd2);
    for (int i = 0; i < 3; i++) read_one(F_CMD, "sat_drain");
    for (int i = 0; i < 3; i++) step();
    check("sat_drained", {31'd0, arb_if.frame_available}, 32'd0);

    // Data waiting behind a stream of dim errors with TX reading continuously.
    arb_if.data_available = 1'b1;
    arb_if.dim_error = 1'b1;
    arb_if.read = 1'b1;
    for (int i = 0; i < 8; i++) step();
    arb_if.dim_error = 1'b0;
    for (int i = 0; i < 20; i++) step();
    arb_if.read = 1'b0;
    arb_if.data_available = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Asynchronous reset while armed with counters nonzero.
    arb_if.rx_error = 8'hF1;
    arb_if.dim_error = 1'b1;
    step();
    drive_idle();
    step();
    check("pre_rst_avail", {31'd0, arb_if.frame_available}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("async_rst_avail", {31'd0, arb_if.frame_available}, 32'd0);
    check("async_rst_ovf", {31'd0, arb_if.err_overflow}, 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("post_rst_quiet", {31'd0, arb_if.frame_available}, 32'd0);

    // Random traffic in three intensity bands.
    for (int seg = 0; seg < 3; seg++) begin
      for (int i = 0; i < 1000; i++) begin
        int rate;
        rate = (seg == 0) ? 8 : ((seg == 1) ? 3 : 2);
        arb_if.rx_error  = ($urandom_range(0, rate) == 0) ? 8'($urandom) : 8'h00;
        arb_if.dim_error = ($urandom_range(0, rate) == 0);
        arb_if.read      = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 15) == 0) arb_if.data_available = ~arb_if.data_available;
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
